// File: rtl/alu_add_scheduler_if.sv
// Request/response bundle for the two-requester add/sub scheduler.
// Signal names match the flat port list of the original block.
interface alu_add_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_op;
  logic [63:0] req0_a;
  logic [63:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_op;
  logic [63:0] req1_a;
  logic [63:0] req1_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_zf;
  logic        rsp_sf;
  logic        rsp_of;

  // Scheduler side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of,
    input  rsp_ready
  );

  // Requester/consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of,
    output rsp_ready
  );
endinterface

// File: rtl/alu_add_scheduler.sv
// Two-requester 64-bit ADD/SUB unit built around a single shared adder.
// SUB is executed as two adder passes: negate b (~b + 1), then a + (-b).
// One operation is in flight at a time; the result is held until consumed.
module alu_add_scheduler #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_add_scheduler_if.slave bus_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NEG  = 2'd1,
    ADD  = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;

  // Captured operation
  logic        op_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        b_sign_q;
  logic        id_q;
  logic        last_q;

  // Registered response
  logic [63:0] res_q;
  logic        zf_q, sf_q, of_q;
  logic        rid_q;

  // Arbitration
  logic        grant_vld;
  logic        grant_id;
  logic        accept;
  logic        sel_op;
  logic [63:0] sel_a;
  logic [63:0] sel_b;

  // Shared adder
  logic [63:0] add_x;
  logic [63:0] add_y;
  logic [63:0] add_sum;
  logic        add_of;
  logic        sub_of;

  // Arbiter: lone requester always wins; on contention either fixed or alternating
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (bus_if.req0_valid && bus_if.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = FIXED_PRIO ? 1'b0 : ~last_q;
    end else if (bus_if.req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (bus_if.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_op = bus_if.req0_op;
    sel_a  = bus_if.req0_a;
    sel_b  = bus_if.req0_b;
    if (grant_id) begin
      sel_op = bus_if.req1_op;
      sel_a  = bus_if.req1_a;
      sel_b  = bus_if.req1_b;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; rst_n gates readys while reset is held
  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    bus_if.req0_ready = 1'b0;
    bus_if.req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld && rst_n) begin
          accept            = 1'b1;
          bus_if.req0_ready = ~grant_id;
          bus_if.req1_ready = grant_id;
          state_d           = sel_op ? NEG : ADD;
        end
      end
      NEG:  state_d = ADD;
      ADD:  state_d = RESP;
      RESP: begin
        if (bus_if.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared adder: NEG pass feeds ~b and 1, otherwise a and captured b
  always_comb begin
    add_x = a_q;
    add_y = b_q;
    if (state_q == NEG) begin
      add_x = ~b_q;
      add_y = 64'd1;
    end
    add_sum = add_x + add_y;
    add_of  = (add_x[63] == add_y[63]) && (add_sum[63] != add_x[63]);
  end

  // SUB overflow uses the original b sign, so negating the most negative value
  // in the NEG pass does not by itself flag overflow.
  always_comb begin
    sub_of = (a_q[63] != b_sign_q) && (add_sum[63] != a_q[63]);
  end

  // Operand capture, negation write-back and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      b_sign_q <= 1'b0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      res_q    <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      rid_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= sel_op;
        a_q      <= sel_a;
        b_q      <= sel_b;
        b_sign_q <= sel_b[63];
        id_q     <= grant_id;
        last_q   <= grant_id;
      end
      if (state_q == NEG) begin
        b_q <= add_sum;
      end
      if (state_q == ADD) begin
        res_q <= add_sum;
        zf_q  <= (add_sum == '0);
        sf_q  <= add_sum[63];
        of_q  <= op_q ? sub_of : add_of;
        rid_q <= id_q;
      end
    end
  end

  // Response outputs
  always_comb begin
    bus_if.rsp_valid  = (state_q == RESP);
    bus_if.rsp_id     = rid_q;
    bus_if.rsp_result = res_q;
    bus_if.rsp_zf     = zf_q;
    bus_if.rsp_sf     = sf_q;
    bus_if.rsp_of     = of_q;
  end

endmodule

// File: tb/tb_alu_add_scheduler.sv
// Bench for alu_add_scheduler: round-robin and fixed-priority instances share stimulus.
module tb_alu_add_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_add_scheduler_if ifc ();
  alu_add_scheduler_if ifp ();

  assign ifp.req0_valid = ifc.req0_valid;
  assign ifp.req0_op    = ifc.req0_op;
  assign ifp.req0_a     = ifc.req0_a;
  assign ifp.req0_b     = ifc.req0_b;
  assign ifp.req1_valid = ifc.req1_valid;
  assign ifp.req1_op    = ifc.req1_op;
  assign ifp.req1_a     = ifc.req1_a;
  assign ifp.req1_b     = ifc.req1_b;
  assign ifp.rsp_ready  = ifc.rsp_ready;

  alu_add_scheduler #(.FIXED_PRIO(1'b0)) dut    (.clk(clk), .rst_n(rst_n), .bus_if(ifc.slave));
  alu_add_scheduler #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus_if(ifp.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  // Reference: 65-bit signed arithmetic, overflow when the result leaves 64-bit range
  function automatic exp_t model(input logic op, input logic [63:0] a, input logic [63:0] b);
    exp_t m;
    logic signed [64:0] w;
    if (op) w = $signed({a[63], a}) - $signed({b[63], b});
    else    w = $signed({a[63], a}) + $signed({b[63], b});
    m.res = w[63:0];
    m.zf  = (w[63:0] == 64'd0);
    m.sf  = w[63];
    m.of  = (w[64] != w[63]);
    return m;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble_inputs();
    ifc.req0_op = 1'($urandom_range(0, 1));
    ifc.req0_a  = rnd64();
    ifc.req0_b  = rnd64();
    ifc.req1_op = 1'($urandom_range(0, 1));
    ifc.req1_a  = rnd64();
    ifc.req1_b  = rnd64();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.rsp_ready  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one operation on a single requester and collects the response (rsp_ready assumed high)
  task automatic send(input logic id, input logic op, input logic [63:0] a, input logic [63:0] b,
                      output int lat, output logic acc, output exp_t got, output logic rid);
    @(negedge clk);
    scramble_inputs();
    ifc.req0_valid = (id == 1'b0);
    ifc.req1_valid = (id == 1'b1);
    if (id == 1'b0) begin
      ifc.req0_op = op; ifc.req0_a = a; ifc.req0_b = b;
    end else begin
      ifc.req1_op = op; ifc.req1_a = a; ifc.req1_b = b;
    end
    #1;
    acc = id ? ifc.req1_ready : ifc.req0_ready;
    @(posedge clk);
    @(negedge clk);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    got = 'x;
    rid = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      if (ifc.rsp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    if (lat != 0) begin
      got.res = ifc.rsp_result;
      got.zf  = ifc.rsp_zf;
      got.sf  = ifc.rsp_sf;
      got.of  = ifc.rsp_of;
      rid     = ifc.rsp_id;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    #2;
    n_cmp++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_readys: got %b expected 00", {ifc.req0_ready, ifc.req1_ready});
    end
    n_cmp++;
    if (ifc.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", ifc.rsp_valid);
    end
    n_cmp++;
    if (ifc.rsp_result !== 64'd0) begin
      n_bad++; $display("FAIL reset_result: got %h expected 0", ifc.rsp_result);
    end
    n_cmp++;
    if ({ifc.rsp_id, ifc.rsp_zf, ifc.rsp_sf, ifc.rsp_of} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_id_flags: got %b expected 0000",
                        {ifc.rsp_id, ifc.rsp_zf, ifc.rsp_sf, ifc.rsp_of});
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        id;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    exp_t        e;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[5];
    int lat; logic acc; exp_t got; logic rid;
    v[0] = '{1'b0, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFB,
             '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b0}, 2};
    v[1] = '{1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
             '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1}, 2};
    v[2] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001,
             '{64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b1}, 2};
    v[3] = '{1'b0, 1'b1, 64'd0, 64'h8000_0000_0000_0000,
             '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1}, 3};
    v[4] = '{1'b0, 1'b1, 64'd5, 64'd5,
             '{64'd0, 1'b1, 1'b0, 1'b0}, 3};
    for (int i = 0; i < 5; i++) begin
      send(v[i].id, v[i].op, v[i].a, v[i].b, lat, acc, got, rid);
      n_cmp++;
      if (acc !== 1'b1) begin
        n_bad++; $display("FAIL dir%0d_accept: got %b expected 1", i, acc);
      end
      n_cmp++;
      if (lat != v[i].lat) begin
        n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
      end
      n_cmp++;
      if (got !== v[i].e) begin
        n_bad++; $display("FAIL dir%0d_result: got %h/zsv=%b%b%b expected %h/zsv=%b%b%b", i,
                          got.res, got.zf, got.sf, got.of, v[i].e.res, v[i].e.zf, v[i].e.sf, v[i].e.of);
      end
      n_cmp++;
      if (rid !== v[i].id) begin
        n_bad++; $display("FAIL dir%0d_id: got %b expected %b", i, rid, v[i].id);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] corner[6];
    int lat; logic acc; exp_t got; logic rid; exp_t e;
    logic id, op;
    logic [63:0] a, b;
    corner[0] = 64'd0;
    corner[1] = 64'd1;
    corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    corner[4] = 64'h8000_0000_0000_0000;
    corner[5] = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : rnd64();
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : rnd64();
      e  = model(op, a, b);
      send(id, op, a, b, lat, acc, got, rid);
      n_cmp++;
      if (lat != (op ? 3 : 2)) begin
        n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, op ? 3 : 2);
      end
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h/zsv=%b%b%b expected %h/zsv=%b%b%b",
                          i, op, a, b, got.res, got.zf, got.sf, got.of, e.res, e.zf, e.sf, e.of);
      end
      n_cmp++;
      if (rid !== id) begin
        n_bad++; $display("FAIL rnd%0d_id: got %b expected %b", i, rid, id);
      end
    end
  endtask

  task automatic test_arbitration();
    int g_rr[$];
    int g_fp[$];
    do_reset();
    @(negedge clk);
    ifc.req0_valid = 1'b1; ifc.req0_op = 1'b0; ifc.req0_a = rnd64(); ifc.req0_b = rnd64();
    ifc.req1_valid = 1'b1; ifc.req1_op = 1'b0; ifc.req1_a = rnd64(); ifc.req1_b = rnd64();
    ifc.rsp_ready  = 1'b1;
    for (int c = 0; c < 80 && (g_rr.size() < 4 || g_fp.size() < 4); c++) begin
      #1;
      n_cmp++;
      if ((ifc.req0_ready && ifc.req1_ready) || (ifp.req0_ready && ifp.req1_ready)) begin
        n_bad++; $display("FAIL arb_both_ready: got rr=%b%b fp=%b%b expected one-hot",
                          ifc.req0_ready, ifc.req1_ready, ifp.req0_ready, ifp.req1_ready);
      end
      if (ifc.req0_ready) g_rr.push_back(0);
      else if (ifc.req1_ready) g_rr.push_back(1);
      if (ifp.req0_ready) g_fp.push_back(0);
      else if (ifp.req1_ready) g_fp.push_back(1);
      @(negedge clk);
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    n_cmp++;
    if (g_rr.size() < 4 || g_fp.size() < 4) begin
      n_bad++; $display("FAIL arb_grant_count: got rr=%0d fp=%0d expected >=4 each", g_rr.size(), g_fp.size());
    end
    for (int i = 0; i < 4 && i < g_rr.size(); i++) begin
      n_cmp++;
      if (g_rr[i] != (i % 2)) begin
        n_bad++; $display("FAIL arb_rr_grant%0d: got %0d expected %0d", i, g_rr[i], i % 2);
      end
    end
    for (int i = 0; i < 4 && i < g_fp.size(); i++) begin
      n_cmp++;
      if (g_fp[i] != 0) begin
        n_bad++; $display("FAIL arb_fp_grant%0d: got %0d expected 0", i, g_fp[i]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_hold();
    exp_t e;
    logic [63:0] a, b;
    int seen;
    a = rnd64();
    b = rnd64();
    e = model(1'b0, a, b);
    @(negedge clk);
    ifc.rsp_ready  = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_op = 1'b0; ifc.req0_a = a; ifc.req0_b = b;
    ifc.req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ifc.rsp_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL hold_rsp_seen: got %0d expected 1", seen);
    end
    // Three stalled cycles, then a fourth with rsp_ready raised
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ifc.rsp_ready = 1'b1;
      #1;
      n_cmp++;
      if ({ifc.rsp_valid, ifc.rsp_result, ifc.rsp_zf, ifc.rsp_sf, ifc.rsp_of, ifc.rsp_id} !==
          {1'b1, e.res, e.zf, e.sf, e.of, 1'b0}) begin
        n_bad++; $display("FAIL hold_cycle%0d_rsp: got v=%b %h/zsv=%b%b%b id=%b expected v=1 %h/zsv=%b%b%b id=0",
                          k, ifc.rsp_valid, ifc.rsp_result, ifc.rsp_zf, ifc.rsp_sf, ifc.rsp_of, ifc.rsp_id,
                          e.res, e.zf, e.sf, e.of);
      end
      n_cmp++;
      if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin
        n_bad++; $display("FAIL hold_cycle%0d_readys: got %b expected 00", k, {ifc.req0_ready, ifc.req1_ready});
      end
      @(negedge clk);
      scramble_inputs();
    end
    #1;
    n_cmp++;
    if (ifc.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_consumed: got rsp_valid=%b expected 0", ifc.rsp_valid);
    end
    n_cmp++;
    if ((ifc.req0_ready | ifc.req1_ready) !== 1'b1) begin
      n_bad++; $display("FAIL hold_next_accept: got %b expected a ready", {ifc.req0_ready, ifc.req1_ready});
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int spur;
    do_reset();
    @(negedge clk);
    ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
    ifc.req0_op = 1'b0; ifc.req1_op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    ifc.req0_valid = 1'b1; ifc.req0_op = 1'b1; ifc.req0_a = rnd64(); ifc.req0_b = rnd64();
    @(posedge clk);
    @(negedge clk);
    ifc.req0_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    spur = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (ifc.rsp_valid !== 1'b0) spur++;
    end
    n_cmp++;
    if (spur != 0) begin
      n_bad++; $display("FAIL midreset_no_rsp: got %0d valid cycles expected 0", spur);
    end
    ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL midreset_grant: got %b expected 10", {ifc.req0_ready, ifc.req1_ready});
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.rsp_ready  = 1'b1;
    scramble_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_arbitration();
    test_hold();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_add_scheduler.md
ALU_ADD_SCHEDULER -- requirements
Module: alu_add_scheduler

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin between requesters, 1 = requester 0 always wins contention.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_op  input  1  0 = ADD (a+b), 1 = SUB (a-b).
REQ-007 req0_a, req0_b  input  64 each  signed two's-complement operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths/meaning for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result when high with rsp_valid.
REQ-011 rsp_id  output  1  requester index owning the result.
REQ-012 rsp_result  output  64  sum/difference, modulo 2^64.
REQ-013 rsp_zf, rsp_sf, rsp_of  output  1 each  zero, sign, signed-overflow flags.

Function
REQ-014 Block SHALL contain exactly one 64-bit combinational adder (a, b -> sum, overflow, no carry-in), shared by all passes and requesters.
REQ-015 FSM states SHALL be IDLE, NEG, ADD, RESP.
REQ-016 IDLE: reqN_ready SHALL be high only for the granted requester, combinationally; both readys low in all other states.
REQ-017 Contention with FIXED_PRIO=0: grant the requester not granted last; last-grant register resets to 1 (requester 0 wins first contention).
REQ-018 Single valid requester SHALL be granted regardless of last-grant.
REQ-019 On accept: capture op, a, b, id; ADD -> state ADD; SUB -> state NEG.
REQ-020 NEG: adder computes (~b)+1 (adder inputs ~b and 64'd1); sum replaces captured b; next state ADD.
REQ-021 ADD: adder computes a + captured b; register result; next state RESP.
REQ-022 RESP: rsp_valid high; rsp_result, rsp_id, flags stable until rsp_valid && rsp_ready, then IDLE.
REQ-023 No new request SHALL be accepted in the cycle the response is consumed; earliest next accept is the following cycle.
REQ-024 Latency accept-to-rsp_valid: ADD 2 cycles, SUB 3 cycles.
REQ-025 rsp_zf = (result == 0); rsp_sf = result[63].
REQ-026 rsp_of for ADD = a[63]==b[63] && result[63]!=a[63]; for SUB = a[63]!=b[63] && result[63]!=a[63], using original operands (negation overflow of 0x8000_0000_0000_0000 in NEG SHALL NOT set OF by itself).
REQ-027 Request inputs changing while not accepted SHALL have no effect; captured operands SHALL be immune to input changes after accept.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, flags 0, last-grant 1.
REQ-029 Reset during NEG/ADD/RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-030 reqN_ready SHALL be low while rst_n is low.

Verification
REQ-031 req0 ADD a=1, b=-5 -> 2 cycles later rsp_result=0xFFFF_FFFF_FFFF_FFFC, id 0, zf0 sf1 of0.
REQ-032 req1 ADD a=b=0x7FFF_FFFF_FFFF_FFFF -> rsp_result=0xFFFF_FFFF_FFFF_FFFE, of1 sf1; then ADD a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0001 -> result 0x1, of1 sf0.
REQ-033 req0 SUB a=0, b=0x8000_0000_0000_0000 -> 3 cycles later result 0x8000_0000_0000_0000, of1 sf1; SUB 5-5 -> result 0, zf1 of0.
REQ-034 Both valid continuously, FIXED_PRIO=0 -> grants 0,1,0,1; FIXED_PRIO=1 -> grants 0,0,0.
REQ-035 rsp_ready low 3 cycles in RESP -> outputs held constant, both readys low; consumed on 4th cycle, accept possible cycle after.
REQ-036 rst_n pulsed low during NEG of a SUB -> rsp_valid stays 0, state IDLE, next request granted to requester 0 on contention.
